// File: rtl/sram_read_streamer_if.sv
// Burst command, SRAM read port and output stream bundle for sram_read_streamer.
// master = streamer side, slave = command source / SRAM / stream consumer side.
interface sram_read_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  sram_cs_n;
  logic                  sram_we_n;
  logic                  sram_re_n;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_data_out;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  cmd_valid, cmd_base, cmd_len, sram_data_out, out_ready,
    output cmd_ready, sram_cs_n, sram_we_n, sram_re_n, sram_addr,
           out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len, sram_data_out, out_ready,
    input  cmd_ready, sram_cs_n, sram_we_n, sram_re_n, sram_addr,
           out_valid, out_data, out_last
  );
endinterface

// File: rtl/sram_read_streamer.sv
// Burst reader: one SRAM read per cycle, 2-word credit window, valid/ready output stream.
// Defining STREAMER_PERF_EN adds the stall_cycles counter and issue_stall flag.
module sram_read_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  sram_read_streamer_if.master bus,
  output logic                 busy,
  output logic                 done
`ifdef STREAMER_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic                 issue_stall
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [DATA_WIDTH-1:0] fifo_dat [2];
  logic [1:0]            fifo_last;
  logic [1:0]            count_q;
  logic                  wr_ptr;
  logic                  rd_ptr;

  logic       cmd_acc;
  logic [1:0] occ;
  logic       credit_ok;
  logic       issue;
  logic       issue_last;
  logic       head_vld;
  logic       out_vld;
  logic       pop;
  logic       fifo_pop;
  logic       push;
  logic       drain_empty;

  // Words buffered plus the one read in flight never exceed the two FIFO slots.
  assign cmd_acc     = (state == ST_IDLE) && bus.cmd_valid;
  assign occ         = count_q + {1'b0, inflight_q};
  assign credit_ok   = (occ < 2'd2);
  assign issue       = (state == ST_STREAM) && credit_ok;
  assign issue_last  = (idx_q == len_q - LEN_WIDTH'(1));
  assign head_vld    = (count_q != 2'd0);
  assign out_vld     = head_vld || inflight_q;
  assign pop         = out_vld && bus.out_ready;
  assign fifo_pop    = pop && head_vld;
  assign push        = inflight_q && !(pop && !head_vld);
  assign drain_empty = (occ == 2'd0) || ((occ == 2'd1) && pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (cmd_acc) state_nxt = (bus.cmd_len == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (issue && issue_last) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_empty) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == ST_IDLE);
    busy          = (state == ST_STREAM) || (state == ST_DRAIN);
    done          = (state == ST_DONE);
    bus.sram_cs_n = !issue;
    bus.sram_re_n = !issue;
    bus.sram_we_n = 1'b1;
    bus.sram_addr = addr_q;
  end

  // The in-flight word is presented straight from the macro so the first word
  // is visible the cycle after issue; it lands in the FIFO only if not taken.
  always_comb begin
    bus.out_valid = out_vld;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (head_vld) begin
      bus.out_data = fifo_dat[rd_ptr];
      bus.out_last = fifo_last[rd_ptr];
    end else if (inflight_q) begin
      bus.out_data = bus.sram_data_out;
      bus.out_last = inflight_last_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q          <= '0;
      len_q           <= '0;
      idx_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_last       <= '0;
      count_q         <= '0;
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_dat[i] <= '0;
    end else begin
      if (cmd_acc) begin
        addr_q <= bus.cmd_base;
        len_q  <= bus.cmd_len;
        idx_q  <= '0;
      end else if (issue) begin
        // Explicit wrap so non-power-of-2 depths return to address 0.
        addr_q <= (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
        idx_q  <= idx_q + LEN_WIDTH'(1);
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
      if (push) begin
        fifo_dat[wr_ptr]  <= bus.sram_data_out;
        fifo_last[wr_ptr] <= inflight_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      unique case ({push, fifo_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef STREAMER_PERF_EN
  always_ff @(posedge clock) begin
    if (reset || cmd_acc) begin
      stall_cycles <= '0;
    end else if (out_vld && !bus.out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign issue_stall = (state == ST_STREAM) && !credit_ok;
`endif

endmodule

// File: tb/tb_sram_read_streamer.sv
// Directed + randomized bursts against an SRAM array model and a word-index scoreboard.
module tb_sram_read_streamer;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int LW    = 6;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;
`ifdef STREAMER_PERF_EN
  logic [31:0] stall_cycles;
  logic        issue_stall;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  sram_read_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  sram_read_streamer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
`ifdef STREAMER_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .issue_stall  (issue_stall)
`endif
  );

  // Synchronous SRAM read port with one cycle of latency.
  always @(posedge clk) begin
    if (!bus.sram_cs_n && !bus.sram_re_n) bus.sram_data_out <= mem[bus.sram_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc - 1) % 3) == 0;
      2:       return $urandom_range(0, 3) != 0;
      default: return !(cyc >= 2 && cyc <= 6);
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    check({tag, "_cs_n"},      64'(bus.sram_cs_n), 64'(1));
    check({tag, "_we_n"},      64'(bus.sram_we_n), 64'(1));
    check({tag, "_re_n"},      64'(bus.sram_re_n), 64'(1));
    check({tag, "_addr"},      64'(bus.sram_addr), 64'(0));
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_out_data"},  64'(bus.out_data),  64'(0));
    check({tag, "_out_last"},  64'(bus.out_last),  64'(0));
    check({tag, "_busy"},      64'(busy),          64'(0));
    check({tag, "_done"},      64'(done),          64'(0));
`ifdef STREAMER_PERF_EN
    check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(0));
    check({tag, "_issue_stall"},  64'(issue_stall),  64'(0));
`endif
  endtask

  // mode 0: ready high, 1: ready 1,0,0,... plus stray commands, 2: random ready,
  // 3: ready low for cycles 2..6.
  task automatic run_burst(input int base, input int len, input int mode, input string tag);
    int n_iss = 0;
    int n_xfer = 0;
    int first_vld = -1;
    int last_x = -1;
    int done_cyc = -1;
    int budget = len * 4 + 20;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base[AW-1:0];
    bus.cmd_len   = len[LW-1:0];
    @(posedge clk);
    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.cmd_valid = (mode == 1) && (cyc >= 2);
      bus.cmd_base  = AW'($urandom);
      bus.cmd_len   = LW'($urandom_range(1, DEPTH));
      bus.out_ready = ready_for(mode, cyc);
      #1;
      check({tag, "_we_n"}, 64'(bus.sram_we_n), 64'(1));
      if (prev_stall) begin
        check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_hold_data"},  64'(bus.out_data),  64'(prev_dat));
      end
`ifdef STREAMER_PERF_EN
      check({tag, "_issue_stall"}, 64'(issue_stall), 64'((n_iss < len) && (n_iss - n_xfer >= 2)));
      if (cyc == 1) check({tag, "_stall_clr"}, 64'(stall_cycles), 64'(0));
`endif
      if (!bus.sram_re_n) begin
        check({tag, "_cs_n"},   64'(bus.sram_cs_n), 64'(0));
        check({tag, "_addr"},   64'(bus.sram_addr), 64'((base + n_iss) % DEPTH));
        check({tag, "_credit"}, 64'((n_iss - n_xfer) < 2), 64'(1));
        n_iss++;
      end
      if (done) begin
        done_cyc = cyc;
        bus.cmd_valid = 1'b0;
        check({tag, "_done_busy"},  64'(busy), 64'(0));
        check({tag, "_done_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_done_cycle"}, 64'(cyc), 64'((len == 0) ? 1 : last_x + 1));
      end else begin
        check({tag, "_busy"},      64'(busy), 64'(1));
        check({tag, "_ready_low"}, 64'(bus.cmd_ready), 64'(0));
        if (bus.out_valid) begin
          if (first_vld < 0) first_vld = cyc;
          if (bus.out_ready) begin
            check({tag, "_data"}, 64'(bus.out_data), 64'(mem[(base + n_xfer) % DEPTH]));
            check({tag, "_last"}, 64'(bus.out_last), 64'(n_xfer == len - 1));
            n_xfer++;
            last_x = cyc;
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_dat   = bus.out_data;
    end
    check({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'(1));
    check({tag, "_n_issued"},  64'(n_iss),  64'(len));
    check({tag, "_n_xfer"},    64'(n_xfer), 64'(len));
    if (len == 0) check({tag, "_no_valid"}, 64'(first_vld < 0), 64'(1));
    if (mode == 0 && len > 0) begin
      check({tag, "_first_lat"},  64'(first_vld), 64'(2));
      check({tag, "_throughput"}, 64'(last_x - first_vld), 64'(len - 1));
    end
    @(negedge clk);
    #1;
    check({tag, "_idle_ready"}, 64'(bus.cmd_ready), 64'(1));
    check({tag, "_idle_done"},  64'(done), 64'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA0 + 32'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    run_burst(4, 8, 0, "b4_l8");
    run_burst(30, 4, 0, "wrap");
    run_burst(0, 6, 1, "toggle");
    run_burst(0, 0, 0, "len0");

    // Reset after the third of ten reads has issued.
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = '0;
    bus.cmd_len   = LW'(10);
    bus.out_ready = 1'b1;
    @(posedge clk);
    n = 0;
    for (int cyc = 1; cyc <= 10 && n < 3; cyc++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      if (!bus.sram_re_n) n++;
    end
    check("mid_issued", 64'(n), 64'(3));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_vals("mid_rst");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("mid_rst_no_done",  64'(done), 64'(0));
      check("mid_rst_no_valid", 64'(bus.out_valid), 64'(0));
      check("mid_rst_no_read",  64'(bus.sram_re_n), 64'(1));
    end
    run_burst(0, 2, 0, "post_rst");

`ifdef STREAMER_PERF_EN
    run_burst(0, 4, 3, "perf");
    check("perf_stall_cycles", 64'(stall_cycles), 64'(5));
`endif

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), 2, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
